// File: rtl/boot_loader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | boot_loader_if : byte stream in, instruction-memory write port out          |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // master: stream source and instruction memory; slave: the loader
    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | boot_loader : framed byte-stream image loader that holds the core in reset  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module boot_loader #(
    parameter int IMEM_DEPTH = 1024,
    parameter int ADDR_W     = 10
) (
    input  wire logic          clk,
    input  wire logic          rst,
    boot_loader_if.slave       bus,
    input  wire logic          reload,
    output logic               core_rst,
    output logic               load_done,
    output logic               load_err,
    output logic [ADDR_W:0]    words_loaded
);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_LOAD = 3'd1,
        S_CSUM = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            state_q,        state_d;
    logic [1:0]        byte_cnt_q,     byte_cnt_d;
    logic [31:0]       word_q,         word_d;
    logic [ADDR_W:0]   n_q,            n_d;
    logic [ADDR_W-1:0] addr_q,         addr_d;
    logic [31:0]       sum_q,          sum_d;
    logic [ADDR_W:0]   wl_q,           wl_d;
    logic              imem_we_q,      imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q,    imem_addr_d;
    logic [31:0]       imem_wdata_q,   imem_wdata_d;
    logic              core_rst_q,     core_rst_d;
    logic              load_done_q,    load_done_d;
    logic              load_err_q,     load_err_d;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_last_byte;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_wl_inc;

    assign w_in_ready  = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CSUM);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_last_byte = (byte_cnt_q == 2'd3);
    assign w_wl_inc    = wl_q + (ADDR_W+1)'(1);

    always_comb begin
        w_word                          = word_q;
        w_word[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;

        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        n_d          = n_q;
        addr_d       = addr_q;
        sum_d        = sum_q;
        wl_d         = wl_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_rst_d   = core_rst_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;

        case (state_q)
            S_HDR, S_LOAD, S_CSUM: begin
                if (w_accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    word_d     = w_last_byte ? 32'd0 : w_word;
                    if (w_last_byte) begin
                        case (state_q)
                            S_HDR: begin
                                if (w_word > 32'(IMEM_DEPTH)) begin
                                    state_d    = S_ERR;
                                    load_err_d = 1'b1;
                                end else if (w_word == 32'd0) begin
                                    state_d = S_CSUM;
                                end else begin
                                    state_d = S_LOAD;
                                    n_d     = w_word[ADDR_W:0];
                                    addr_d  = '0;
                                    sum_d   = '0;
                                end
                            end
                            S_LOAD: begin
                                imem_we_d    = 1'b1;
                                imem_addr_d  = addr_q;
                                imem_wdata_d = w_word;
                                sum_d        = sum_q + w_word;
                                addr_d       = addr_q + ADDR_W'(1);
                                wl_d         = w_wl_inc;
                                if (w_wl_inc == n_q) begin
                                    state_d = S_CSUM;
                                end
                            end
                            default: begin
                                if (w_word == sum_q) begin
                                    state_d     = S_RUN;
                                    load_done_d = 1'b1;
                                    core_rst_d  = 1'b0;
                                end else begin
                                    state_d    = S_ERR;
                                    load_err_d = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            default: begin
                if (reload) begin
                    state_d     = S_HDR;
                    byte_cnt_d  = '0;
                    word_d      = '0;
                    n_d         = '0;
                    addr_d      = '0;
                    sum_d       = '0;
                    wl_d        = '0;
                    core_rst_d  = 1'b1;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_HDR;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            n_q          <= '0;
            addr_q       <= '0;
            sum_q        <= '0;
            wl_q         <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            n_q          <= n_d;
            addr_q       <= addr_d;
            sum_q        <= sum_d;
            wl_q         <= wl_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign core_rst       = core_rst_q;
    assign load_done      = load_done_q;
    assign load_err       = load_err_q;
    assign words_loaded   = wl_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_boot_loader : randomized image loads checked against an image-level model|
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_boot_loader;
    localparam int IMEM_DEPTH = 1024;
    localparam int ADDR_W     = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              reload = 1'b0;
    logic              core_rst;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    boot_loader #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .reload       (reload),
        .core_rst     (core_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe seen mid-cycle is logged
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    bit                loading = 1'b0;
    int                rst_low_cnt = 0;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
        if (loading && core_rst !== 1'b1) rst_low_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] img_sum(input logic [31:0] q[$]);
        logic [31:0] s = 32'd0;
        foreach (q[i]) s = s + q[i];
        return s;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, ":in_ready"},     bus.in_ready,   1);
        check({tag, ":imem_we"},      bus.imem_we,    0);
        check({tag, ":imem_addr"},    bus.imem_addr,  0);
        check({tag, ":imem_wdata"},   bus.imem_wdata, 0);
        check({tag, ":core_rst"},     core_rst,       1);
        check({tag, ":load_done"},    load_done,      0);
        check({tag, ":load_err"},     load_err,       0);
        check({tag, ":words_loaded"}, words_loaded,   0);
    endtask

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        check("reload:core_rst",     core_rst,     1);
        check("reload:load_done",    load_done,    0);
        check("reload:load_err",     load_err,     0);
        check("reload:in_ready",     bus.in_ready, 1);
        check("reload:words_loaded", words_loaded, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int waited = 0;
        while ($urandom_range(0, 99) < gap_pct && waited < 4) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk); #1;
            waited++;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("in_ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_pct);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_pct);
    endtask

    // Image-level model: oversize header rejects with no writes, otherwise
    // all N words land at addresses 0..N-1 and the image passes iff C == sum.
    task automatic run_image(input string name, input logic [31:0] n,
                             input logic [31:0] words[$], input logic [31:0] csum,
                             input int gap_pct);
        int  exp_writes;
        bit  exp_ok;
        int  nw;
        exp_writes = (n <= 32'(IMEM_DEPTH)) ? int'(n) : 0;
        exp_ok     = (n <= 32'(IMEM_DEPTH)) && (csum == img_sum(words));
        wr_addr.delete();
        wr_data.delete();
        rst_low_cnt = 0;
        loading = 1'b1;
        send_word(n, gap_pct);
        if (n > 32'(IMEM_DEPTH)) begin
            loading = 1'b0;
            check({name, ":hdr_err"},      load_err,     1);
            check({name, ":hdr_in_ready"}, bus.in_ready, 0);
        end else begin
            for (int i = 0; i < int'(n); i++) send_word(words[i], gap_pct);
            send_word(csum, gap_pct);
            loading = 1'b0;
            check({name, ":done"},     load_done, exp_ok);
            check({name, ":err"},      load_err,  !exp_ok);
            check({name, ":core_rst"}, core_rst,  !exp_ok);
        end
        repeat (3) begin @(posedge clk); #1; end
        check({name, ":in_ready_end"}, bus.in_ready, 0);
        check({name, ":words_loaded"}, words_loaded, exp_writes);
        check({name, ":n_writes"},     wr_addr.size(), exp_writes);
        check({name, ":core_rst_held"}, rst_low_cnt, 0);
        nw = (wr_addr.size() < exp_writes) ? wr_addr.size() : exp_writes;
        for (int i = 0; i < nw; i++) begin
            check({name, ":waddr"}, wr_addr[i], i);
            check({name, ":wdata"}, wr_data[i], words[i]);
        end
    endtask

    logic [31:0] img[$];
    logic [31:0] empty[$];
    logic [31:0] one[$];
    logic [31:0] rimg[$];

    initial begin
        bus.in_data  = 8'd0;
        bus.in_valid = 1'b0;
        img   = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        one   = '{32'hDEADBEEF};
        empty = {};

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b1;

        run_image("basic", 32'd3, img, img_sum(img), 0);

        do_reload();
        run_image("reload_one", 32'd1, one, 32'hDEADBEEF, 0);

        apply_reset();
        run_image("bad_csum", 32'd3, img, img_sum(img) + 32'd1, 0);

        apply_reset();
        run_image("oversize", 32'(IMEM_DEPTH + 1), empty, 32'd0, 0);

        apply_reset();
        run_image("empty_ok", 32'd0, empty, 32'd0, 0);
        apply_reset();
        run_image("empty_bad", 32'd0, empty, 32'd1, 0);

        apply_reset();
        run_image("gapped", 32'd3, img, img_sum(img), 50);

        // abort mid-word: header plus two bytes of the first word
        apply_reset();
        send_word(32'd3, 50);
        send_byte(8'h93, 50);
        send_byte(8'h00, 50);
        check("abort:no_writes", wr_addr.size(), 0);
        apply_reset();
        check_reset_state("abort");
        run_image("after_abort", 32'd3, img, img_sum(img), 50);

        // reset and reload together: reset wins
        rst = 1'b0;
        reload = 1'b1;
        @(posedge clk); #1;
        check_reset_state("rst_reload");
        rst = 1'b1;
        reload = 1'b0;

        for (int it = 0; it < 6; it++) begin
            int n;
            logic [31:0] c;
            n = $urandom_range(1, 8);
            rimg = {};
            for (int i = 0; i < n; i++) rimg.push_back($urandom);
            c = img_sum(rimg);
            if ($urandom_range(0, 3) == 0) c = c ^ (32'd1 << $urandom_range(0, 31));
            if (it != 0) begin
                if (it % 2 == 0) apply_reset();
                else do_reload();
            end
            run_image("random", 32'(n), rimg, c, 40);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
